display_scan_reader: RTL
========================

DISPLAY_SCAN_READER -- requirements
Module: display_scan_reader

Interface
REQ-001 Parameter: SETTLE_CYCLES, 4, consecutive identical samples required before a digit is captured (legal range 2..255).
REQ-002 Port: CLK  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: DIGIT  input  4  scanned digit select, active-low one-hot (1110 = digit 0 ... 0111 = digit 3), asynchronous to CLK.
REQ-005 Port: SEG  input  8  segment lines, active-low; bit0=a ... bit6=g, bit7=dp; asynchronous to CLK.
REQ-006 Port: D0, D1, D2, D3  output  4 each  last decoded hex value per digit position.
REQ-007 Port: DVALID  output  4  bit k set once Dk has been captured since reset.
REQ-008 Port: FRAME  output  1  one-cycle pulse when all four positions have been captured since the previous pulse.
REQ-009 Port: ERR  output  1  one-cycle pulse when a settled pattern matches no hex glyph.

Function
REQ-010 DIGIT and SEG SHALL pass through a two-flop synchronizer; all later logic uses only the second stage (s_digit, s_seg).
REQ-011 Stability counter: set to 1 when {s_digit,s_seg} differs from the previous-cycle value; otherwise increment, saturating at SETTLE_CYCLES.
REQ-012 FSM states: IDLE, SETTLE, HOLD.
REQ-013 IDLE: s_digit not exactly one zero bit (blanking or multiple selects); no capture; go to SETTLE on the first cycle s_digit has exactly one zero bit.
REQ-014 SETTLE: on any sample change, restart the count and remain (or go to IDLE if the select becomes invalid); when the count reaches SETTLE_CYCLES, perform one capture and go to HOLD.
REQ-015 HOLD: no further capture of an unchanged pattern; on any sample change, go to SETTLE (valid select) or IDLE (invalid select).
REQ-016 Capture decode: SEG[6:0] compared against standard active-low hex glyphs 0-F (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E on bits 6:0); SEG[7] ignored.
REQ-017 Matched capture: Dk and DVALID[k] updated on the capture edge; Dk visible in the cycle after the capture edge.
REQ-018 Unmatched capture: ERR pulses for one cycle; Dk, DVALID and the frame mask unchanged.
REQ-019 Latency: a pin change stable from edge n produces Dk update at edge n+2+SETTLE_CYCLES.
REQ-020 Frame mask (internal, 4 bits): bit k set on a matched capture of digit k. When the capture completes the mask (1111), FRAME SHALL pulse in the same cycle Dk updates and the mask SHALL clear to 0000, the completing bit not being retained.
REQ-021 Recapture of an already-masked digit SHALL update Dk without pulsing FRAME.

Reset
REQ-022 Asserting RST_N low SHALL immediately clear the synchronizers, D0-D3 (0), DVALID (0000), FRAME (0), ERR (0), the frame mask, and the counter, and force IDLE.
REQ-023 Reset mid-SETTLE SHALL abort the pending capture; after release, capture requires a full fresh settle.

Structure
REQ-024 Shared package display_pkg SHALL hold the FSM state encoding, the 16-entry glyph table and SETTLE_CYCLES default.
REQ-025 Sub-module seg_to_hex (combinational: 7-bit pattern in; 4-bit value and match flag out) SHALL implement REQ-016.

Verification
REQ-026 DIGIT=1110, SEG=B0 held 10 cycles -> D0=3, DVALID=0001 at edge 6; no FRAME, no ERR.
REQ-027 Scan 1110/C0, 1101/F9, 1011/A4, 0111/8E, 8 cycles each -> D0..D3 = 0,1,2,F; FRAME one pulse coincident with D3 update; mask cleared.
REQ-028 DIGIT=1101, SEG toggling B0/80 every 2 cycles for 20 cycles -> no capture, D1 unchanged.
REQ-029 DIGIT=1011, SEG=FF (blank) held -> single ERR pulse, D2 and DVALID unchanged; DIGIT=1111 or 1100 -> IDLE, no ERR.
REQ-030 RST_N low at cycle 2 of SETTLE on 0111/80, released one cycle later -> all outputs 0, D3=8 only after SETTLE_CYCLES+2 further cycles.
REQ-031 Frame 0,1,2,3 then digit 0 recaptured twice with 99 -> D0=4, no second FRAME until all four recaptured.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display scan reader: FSM encoding,
// active-low seven-segment hex glyphs and select-line helpers.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam int SETTLE_CYCLES_DEFAULT = 4;

  // Active-low segment patterns on bits 6:0 (g..a), entry i is hex digit i.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // A select is usable only when exactly one active-low line is asserted.
  function automatic logic sel_valid(input logic [3:0] sel);
    return ($countones(~sel) == 1);
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] sel);
    logic [1:0] idx;
    case (sel)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Combinational decode of an active-low 7-segment pattern to its hex value;
// match is low when the pattern is not one of the sixteen hex glyphs.
module seg_to_hex
  import display_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       match
);

  always_comb begin
    value = '0;
    match = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (GLYPHS[i] == pattern) begin
        value = 4'(i);
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan_reader.sv
// Recovers the four hex digits shown on a multiplexed 7-segment display by
// sampling its digit-select and segment lines and capturing settled patterns.
module display_scan_reader
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] DIGIT,
  input  logic [7:0] SEG,
  output logic [3:0] D0,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic [3:0] DVALID,
  output logic       FRAME,
  output logic       ERR,
  output state_e     dbg_state
);

  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);

  logic [3:0]       sync_digit, s_digit;
  logic [7:0]       sync_seg, s_seg;
  logic [11:0]      prev_sample;
  logic [7:0]       stable_cnt;
  logic             changed;
  logic             sel_ok;
  logic [1:0]       sel_idx;
  state_e           state_q, state_d;
  logic             capture;
  logic [3:0]       seg_value;
  logic             seg_match;
  logic [3:0]       frame_mask, mask_next;
  logic [3:0][3:0]  digit_q;
  logic [3:0]       dvalid_q;
  logic             frame_q, err_q;

  // Two-flop synchronizer; nothing downstream looks at the first stage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_digit <= '0;
      sync_seg   <= '0;
      s_digit    <= '0;
      s_seg      <= '0;
    end else begin
      sync_digit <= DIGIT;
      sync_seg   <= SEG;
      s_digit    <= sync_digit;
      s_seg      <= sync_seg;
    end
  end

  assign changed = ({s_digit, s_seg} != prev_sample);
  assign sel_ok  = sel_valid(s_digit);
  assign sel_idx = sel_index(s_digit);

  // stable_cnt counts how many consecutive cycles prev_sample has been seen.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_sample <= '0;
      stable_cnt  <= '0;
    end else begin
      prev_sample <= {s_digit, s_seg};
      if (changed) begin
        stable_cnt <= 8'd1;
      end else if (stable_cnt != SETTLE_MAX) begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_ok) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!sel_ok) begin
          state_d = ST_IDLE;
        end else if (!changed && stable_cnt == SETTLE_MAX) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (changed) state_d = sel_ok ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  seg_to_hex u_seg_to_hex (
    .pattern (s_seg[6:0]),
    .value   (seg_value),
    .match   (seg_match)
  );

  assign mask_next = frame_mask | (4'b0001 << sel_idx);

  // The completing digit is not kept in the mask: a full frame restarts empty.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      digit_q    <= '0;
      dvalid_q   <= '0;
      frame_mask <= '0;
      frame_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      if (capture) begin
        if (seg_match) begin
          digit_q[sel_idx]  <= seg_value;
          dvalid_q[sel_idx] <= 1'b1;
          if (mask_next == 4'hF) begin
            frame_q    <= 1'b1;
            frame_mask <= '0;
          end else begin
            frame_mask <= mask_next;
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign D0        = digit_q[0];
  assign D1        = digit_q[1];
  assign D2        = digit_q[2];
  assign D3        = digit_q[3];
  assign DVALID    = dvalid_q;
  assign FRAME     = frame_q;
  assign ERR       = err_q;
  assign dbg_state = state_q;

endmodule
